// File: rtl/mandel_iter.sv
// Escape-time iteration engine for one Mandelbrot pixel: iterates z <- z^2 + c in
// signed Q10.22 until |z|^2 > 4.0 or the iteration limit is reached.

module multiplier (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] p
);
    logic signed [63:0] a_ext;
    logic signed [63:0] b_ext;
    logic signed [63:0] product;

    assign a_ext   = {{32{a[31]}}, a};
    assign b_ext   = {{32{b[31]}}, b};
    assign product = a_ext * b_ext;

    // Realign to Q10.22: arithmetic shift by the fraction width, keep the low word.
    assign p = 32'(product >>> 22);
endmodule

module mandel_iter #(
    parameter int MAX_ITER = 255,
    parameter int ITER_W   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [31:0]       c_re,
    input  logic [31:0]       c_im,
    output logic              ready,
    output logic              done,
    output logic [ITER_W-1:0] iter_count,
    output logic              escaped
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MULT = 2'd1,
        EVAL = 2'd2
    } state_t;

    localparam logic [ITER_W-1:0] MAX_N      = ITER_W'(MAX_ITER);
    localparam logic signed [32:0] ESC_LIMIT = 33'sh0_0100_0000;

    state_t            state_reg, state_next;
    logic [31:0]       x_reg, x_next;
    logic [31:0]       y_reg, y_next;
    logic [31:0]       cre_reg, cre_next;
    logic [31:0]       cim_reg, cim_next;
    logic [31:0]       x2_reg, x2_next;
    logic [31:0]       y2_reg, y2_next;
    logic [31:0]       xy_reg, xy_next;
    logic [ITER_W-1:0] n_reg, n_next;
    logic              done_reg, done_next;
    logic [ITER_W-1:0] iter_reg, iter_next;
    logic              esc_reg, esc_next;

    logic [31:0] mul_a [3];
    logic [31:0] mul_b [3];
    logic [31:0] mul_p [3];

    logic signed [32:0] mag_sum;
    logic               escape;
    logic [31:0]        x_upd;
    logic [31:0]        y_upd;

    // Product lanes: 0 = x*x, 1 = y*y, 2 = x*y.
    assign mul_a[0] = x_reg;
    assign mul_b[0] = x_reg;
    assign mul_a[1] = y_reg;
    assign mul_b[1] = y_reg;
    assign mul_a[2] = x_reg;
    assign mul_b[2] = y_reg;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_mul
            multiplier u_mul (
                .a (mul_a[gi]),
                .b (mul_b[gi]),
                .p (mul_p[gi])
            );
        end
    endgenerate

    // Magnitude sum is widened by one bit so two large squares cannot wrap negative.
    assign mag_sum = $signed({x2_reg[31], x2_reg}) + $signed({y2_reg[31], y2_reg});
    assign escape  = (mag_sum > ESC_LIMIT);

    assign x_upd = x2_reg - y2_reg + cre_reg;
    assign y_upd = (xy_reg <<< 1) + cim_reg;

    always_comb begin
        state_next = state_reg;
        x_next     = x_reg;
        y_next     = y_reg;
        cre_next   = cre_reg;
        cim_next   = cim_reg;
        x2_next    = x2_reg;
        y2_next    = y2_reg;
        xy_next    = xy_reg;
        n_next     = n_reg;
        done_next  = 1'b0;
        iter_next  = iter_reg;
        esc_next   = esc_reg;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    cre_next   = c_re;
                    cim_next   = c_im;
                    x_next     = '0;
                    y_next     = '0;
                    n_next     = '0;
                    state_next = MULT;
                end
            end
            MULT: begin
                x2_next    = mul_p[0];
                y2_next    = mul_p[1];
                xy_next    = mul_p[2];
                state_next = EVAL;
            end
            EVAL: begin
                if (escape) begin
                    iter_next  = n_reg;
                    esc_next   = 1'b1;
                    done_next  = 1'b1;
                    state_next = IDLE;
                end else if (n_reg == MAX_N) begin
                    iter_next  = MAX_N;
                    esc_next   = 1'b0;
                    done_next  = 1'b1;
                    state_next = IDLE;
                end else begin
                    x_next     = x_upd;
                    y_next     = y_upd;
                    n_next     = n_reg + ITER_W'(1);
                    state_next = MULT;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            x_reg     <= '0;
            y_reg     <= '0;
            cre_reg   <= '0;
            cim_reg   <= '0;
            x2_reg    <= '0;
            y2_reg    <= '0;
            xy_reg    <= '0;
            n_reg     <= '0;
            done_reg  <= 1'b0;
            iter_reg  <= '0;
            esc_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            x_reg     <= x_next;
            y_reg     <= y_next;
            cre_reg   <= cre_next;
            cim_reg   <= cim_next;
            x2_reg    <= x2_next;
            y2_reg    <= y2_next;
            xy_reg    <= xy_next;
            n_reg     <= n_next;
            done_reg  <= done_next;
            iter_reg  <= iter_next;
            esc_reg   <= esc_next;
        end
    end

    // ready follows the state directly so it rises in the same cycle as done.
    assign ready      = (state_reg == IDLE);
    assign done       = done_reg;
    assign iter_count = iter_reg;
    assign escaped    = esc_reg;
endmodule
